scu_dsp_dma: RTL and testbench
==============================

SCU_DSP_DMA -- requirements
Module: scu_dsp_dma

Interface
REQ-001 SHALL provide parameter NBANK, default 4, number of DSP data RAM banks.
REQ-002 SHALL provide parameter DW, default 32, data word width.
REQ-003 SHALL provide parameter CW, default 8, transfer count width.
REQ-004 SHALL provide parameter QD, default 2, command queue depth (power of two).
REQ-005 Reset SHALL be RST_N, asynchronous, active-low; clock SHALL be CLK.
REQ-006 Ports (name  direction  width  meaning):
  CLK  in  1  clock
  RST_N  in  1  async active-low reset
  CE  in  1  transfer-cycle enable; all state advances only when high
  CMD_VALID  in  1  command offered
  CMD_READY  out  1  command accepted when VALID&READY&CE
  CMD_DIR  in  1  1 = RAM->bus, 0 = bus->RAM
  CMD_BANK  in  $clog2(NBANK)  source/destination bank
  CMD_CNT  in  CW  word count; 0 means 2^CW
  CMD_HOLD  in  1  1 = do not step bank counter
  BUS_REQ  out  1  word request to bus arbiter
  BUS_ACK  in  1  one word transferred this cycle
  BUS_LAST  out  1  current word is final of command
  BUS_END  in  1  bus side finished the command
  BUS_WE  out  1  equals active DIR
  BUS_DO  out  DW  RAM_Q of active bank
  BUS_DI  in  DW  word from bus
  RAM_Q  in  NBANK*DW  read data of all banks
  RAM_D  out  DW  equals BUS_DI
  RAM_WE  out  NBANK  one-hot bank write strobe
  CT_INC  out  NBANK  one-hot bank counter step
  ABORT  in  1  cancel active and queued commands
  BUSY  out  1  command active (DSP T0 flag)
  CNT_REM  out  CW  words remaining in active command

Function
REQ-007 FSM states SHALL be IDLE, XFER, WAIT_END; reset state IDLE.
REQ-008 IDLE: queue non-empty -> pop head, load DIR/BANK/HOLD, CNT_REM <= CNT, BUSY=1, BUS_REQ=1, -> XFER, one cycle after push at earliest.
REQ-009 XFER: ACK while REQ=1 SHALL decrement CNT_REM, pulse CT_INC[BANK] unless HOLD, pulse RAM_WE[BANK] when DIR=0, same cycle.
REQ-010 BUS_REQ SHALL stay 1 in XFER while CNT_REM>1 after the ack; ack of the word with CNT_REM=1 -> BUS_REQ=0, -> WAIT_END.
REQ-011 ACK while BUS_REQ=0 SHALL be ignored.
REQ-012 BUS_LAST SHALL equal (CNT_REM==1) in XFER; CNT_CNT=0 loads 2^CW, CNT_REM reads 0 then until first ack.
REQ-013 WAIT_END: BUS_END -> BUSY=0 next cycle; head pops same cycle if queue non-empty (back-to-back, BUSY stays 1), else IDLE.
REQ-014 BUS_END in XFER SHALL end command early as in REQ-013.
REQ-015 Queue full -> CMD_READY=0; push and pop same cycle on full queue SHALL both succeed.
REQ-016 ABORT SHALL, next cycle, clear queue, BUS_REQ=0, BUSY=0, state IDLE; ABORT wins over simultaneous push.
REQ-017 RAM_WE, CT_INC SHALL be 0 whenever CE=0 or state != XFER.

Reset
REQ-018 Reset SHALL give BUSY=0, BUS_REQ=0, BUS_LAST=0, BUS_WE=0, CNT_REM=0, RAM_WE=0, CT_INC=0, queue empty, CMD_READY=1.
REQ-019 Reset mid-transfer SHALL drop BUS_REQ asynchronously with no further strobes.

Configuration
REQ-020 Macro SCU_DSP_DMA_QUEUE_EN defined: QD-entry queue as above.
REQ-021 Macro undefined: no queue; CMD_READY = ~BUSY & ~ABORT, accepted command starts directly, QD ignored.

Verification
REQ-022 CMD bank 2, CNT=3, DIR=0, ACK every cycle -> 3 RAM_WE[2] and CT_INC[2] pulses, BUS_LAST on 3rd, BUS_END -> BUSY 0.
REQ-023 CNT=0, CW=8 -> exactly 256 acked words before BUS_REQ falls.
REQ-024 DIR=1, HOLD=1, CNT=4 -> BUS_DO tracks RAM_Q bank, CT_INC never pulses, RAM_WE never pulses.
REQ-025 QUEUE_EN, QD=2: push 3 commands while busy -> 3rd stalls on CMD_READY=0, commands run back-to-back with BUSY held 1.
REQ-026 ABORT at CNT_REM=5 with 1 queued -> next cycle BUSY=0, BUS_REQ=0, queue empty, CMD_READY=1.
REQ-027 ACK asserted in IDLE and WAIT_END -> no strobes, CNT_REM unchanged.

Source files
------------

// File: rtl/scu_dsp_dma.sv
// SCU DSP DMA: moves words between the bus and the DSP data RAM banks, one command at a time.
// Define SCU_DSP_DMA_QUEUE_EN to add a QD-deep command queue; when it is undefined, commands start directly.
module scu_dsp_dma #(
  parameter int NBANK = 4,
  parameter int DW    = 32,
  parameter int CW    = 8,
  parameter int QD    = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CE,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic                     CMD_DIR,
  input  logic [$clog2(NBANK)-1:0] CMD_BANK,
  input  logic [CW-1:0]            CMD_CNT,
  input  logic                     CMD_HOLD,
  output logic                     BUS_REQ,
  input  logic                     BUS_ACK,
  output logic                     BUS_LAST,
  input  logic                     BUS_END,
  output logic                     BUS_WE,
  output logic [DW-1:0]            BUS_DO,
  input  logic [DW-1:0]            BUS_DI,
  input  logic [NBANK*DW-1:0]      RAM_Q,
  output logic [DW-1:0]            RAM_D,
  output logic [NBANK-1:0]         RAM_WE,
  output logic [NBANK-1:0]         CT_INC,
  input  logic                     ABORT,
  output logic                     BUSY,
  output logic [CW-1:0]            CNT_REM
);
  localparam int BW = $clog2(NBANK);

  typedef enum logic [1:0] {IDLE, XFER, WAIT_END} state_t;
  typedef struct packed {
    logic          dir;
    logic [BW-1:0] bank;
    logic          hold;
    logic [CW-1:0] cnt;
  } cmd_t;

  state_t           state;
  logic             busy_q, req_q, dir_q, hold_q;
  logic [BW-1:0]    bank_q;
  logic [CW-1:0]    cnt_q;
  cmd_t             new_cmd, start_cmd;
  logic             ack_ok, cmd_end, start;
  logic [NBANK-1:0] bank_oh;

  assign new_cmd = {CMD_DIR, CMD_BANK, CMD_HOLD, CMD_CNT};
  assign ack_ok  = CE & (state == XFER) & req_q & BUS_ACK;
  assign cmd_end = (state != IDLE) & BUS_END;

`ifdef SCU_DSP_DMA_QUEUE_EN
  localparam int QAW = (QD > 1) ? $clog2(QD) : 1;
  localparam int QCW = $clog2(QD + 1);

  cmd_t           q_mem [QD];
  logic [QAW-1:0] rd_idx, wr_idx;
  logic [QCW-1:0] q_cnt;
  logic           q_empty, q_full, push, pop;

  function automatic logic [QAW-1:0] nxt(input logic [QAW-1:0] i);
    return (i == QAW'(QD - 1)) ? '0 : i + QAW'(1);
  endfunction

  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign q_empty   = (q_cnt == '0);
  assign q_full    = (q_cnt == QCW'(QD));
  assign pop       = CE & ~ABORT & ~q_empty & ((state == IDLE) | cmd_end);
  assign CMD_READY = ~ABORT & (~q_full | pop);
  assign push      = CE & CMD_VALID & CMD_READY;
  assign start     = pop;
  assign start_cmd = q_mem[rd_idx];

  always_ff @(posedge CLK) begin
    if (push) q_mem[wr_idx] <= new_cmd;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_idx <= '0;
      wr_idx <= '0;
      q_cnt  <= '0;
    end else if (CE) begin
      if (ABORT) begin
        rd_idx <= '0;
        wr_idx <= '0;
        q_cnt  <= '0;
      end else begin
        if (push) wr_idx <= nxt(wr_idx);
        if (pop)  rd_idx <= nxt(rd_idx);
        if (push && !pop)      q_cnt <= q_cnt + QCW'(1);
        else if (pop && !push) q_cnt <= q_cnt - QCW'(1);
      end
    end
  end
`else
  assign CMD_READY = ~busy_q & ~ABORT;
  assign start     = CE & CMD_VALID & CMD_READY;
  assign start_cmd = new_cmd;
`endif

  // A count of 0 loads as 0 and means 2^CW words: the first ack wraps it to 2^CW-1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      req_q  <= 1'b0;
      dir_q  <= 1'b0;
      hold_q <= 1'b0;
      bank_q <= '0;
      cnt_q  <= '0;
    end else if (CE) begin
      if (ABORT) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        req_q  <= 1'b0;
        cnt_q  <= '0;
      end else if (start) begin
        state  <= XFER;
        busy_q <= 1'b1;
        req_q  <= 1'b1;
        dir_q  <= start_cmd.dir;
        bank_q <= start_cmd.bank;
        hold_q <= start_cmd.hold;
        cnt_q  <= start_cmd.cnt;
      end else if (cmd_end) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        req_q  <= 1'b0;
        cnt_q  <= '0;
      end else if (ack_ok) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state <= WAIT_END;
          req_q <= 1'b0;
        end
      end
    end
  end

  assign bank_oh  = NBANK'(1) << bank_q;
  assign BUSY     = busy_q;
  assign BUS_REQ  = req_q;
  assign BUS_LAST = (state == XFER) & (cnt_q == CW'(1));
  assign BUS_WE   = busy_q & dir_q;
  assign BUS_DO   = RAM_Q[bank_q*DW +: DW];
  assign RAM_D    = BUS_DI;
  assign CNT_REM  = cnt_q;
  assign RAM_WE   = (ack_ok & ~dir_q)  ? bank_oh : '0;
  assign CT_INC   = (ack_ok & ~hold_q) ? bank_oh : '0;

endmodule

// File: tb/tb_scu_dsp_dma.sv
// Bench for scu_dsp_dma: command-level reference model, per-cycle compare, directed and random stimulus.
module tb_scu_dsp_dma;
  localparam int NBANK = 4;
  localparam int DW    = 32;
  localparam int CW    = 8;
  localparam int QD    = 2;
`ifdef SCU_DSP_DMA_QUEUE_EN
  localparam bit QMODE = 1'b1;
`else
  localparam bit QMODE = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic                CE = 1'b0, CMD_VALID = 1'b0, CMD_DIR = 1'b0, CMD_HOLD = 1'b0;
  logic [1:0]          CMD_BANK = '0;
  logic [CW-1:0]       CMD_CNT = '0;
  logic                BUS_ACK = 1'b0, BUS_END = 1'b0, ABORT = 1'b0;
  logic [DW-1:0]       BUS_DI = '0;
  logic [NBANK*DW-1:0] RAM_Q = '0;
  logic                CMD_READY, BUS_REQ, BUS_LAST, BUS_WE, BUSY;
  logic [DW-1:0]       BUS_DO, RAM_D;
  logic [NBANK-1:0]    RAM_WE, CT_INC;
  logic [CW-1:0]       CNT_REM;

  always #5 CLK = ~CLK;

  scu_dsp_dma #(.NBANK(NBANK), .DW(DW), .CW(CW), .QD(QD)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DIR(CMD_DIR),
    .CMD_BANK(CMD_BANK), .CMD_CNT(CMD_CNT), .CMD_HOLD(CMD_HOLD),
    .BUS_REQ(BUS_REQ), .BUS_ACK(BUS_ACK), .BUS_LAST(BUS_LAST), .BUS_END(BUS_END),
    .BUS_WE(BUS_WE), .BUS_DO(BUS_DO), .BUS_DI(BUS_DI), .RAM_Q(RAM_Q),
    .RAM_D(RAM_D), .RAM_WE(RAM_WE), .CT_INC(CT_INC), .ABORT(ABORT),
    .BUSY(BUSY), .CNT_REM(CNT_REM)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command is busy until ended; it requests words while words remain.
  typedef struct {
    bit dir;
    int bank;
    bit hold;
    int cnt;
  } mcmd_t;

  mcmd_t mq[$];
  bit    m_busy = 0, m_xfer = 0, m_dir = 0, m_hold = 0;
  int    m_bank = 0, m_rem = 0;

  bit s_ce, s_valid, s_dir, s_hold, s_ack, s_end, s_abort;
  int s_bank, s_cnt;

  int acc_we, acc_ct, acc_last, acc_acked, acc_busy_low, acc_buswe;

  task automatic clear_acc();
    acc_we = 0; acc_ct = 0; acc_last = 0; acc_acked = 0; acc_busy_low = 0; acc_buswe = 0;
  endtask

  task automatic set_idle();
    s_ce = 1; s_valid = 0; s_dir = 0; s_hold = 0; s_ack = 0; s_end = 0; s_abort = 0;
    s_bank = 0; s_cnt = 1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0;
    m_xfer = 0;
    m_rem  = 0;
  endtask

  task automatic model_load(input mcmd_t c);
    m_busy = 1;
    m_xfer = 1;
    m_dir  = c.dir;
    m_bank = c.bank;
    m_hold = c.hold;
    m_rem  = (c.cnt == 0) ? (1 << CW) : c.cnt;
  endtask

  // One clock: apply staged inputs after the edge, compare mid-cycle, advance the model.
  task automatic step();
    bit               ack, e_ready, accept, done, was_idle;
    logic [NBANK-1:0] oh;
    mcmd_t            c, nc;
    @(posedge CLK);
    #1;
    CE = s_ce; CMD_VALID = s_valid; CMD_DIR = s_dir; CMD_HOLD = s_hold;
    CMD_BANK = 2'(s_bank); CMD_CNT = CW'(s_cnt);
    BUS_ACK = s_ack; BUS_END = s_end; ABORT = s_abort;
    BUS_DI = $urandom();
    for (int b = 0; b < NBANK; b++) RAM_Q[b*DW +: DW] = $urandom();
    #2;
    if (QMODE)
      e_ready = !ABORT && (mq.size() < QD || (CE && mq.size() > 0 && (!m_busy || BUS_END)));
    else
      e_ready = !m_busy && !ABORT;
    ack = CE && BUS_ACK && m_xfer;
    oh  = NBANK'(1) << m_bank;

    chk("busy", BUSY, m_busy);
    chk("bus_req", BUS_REQ, m_xfer);
    chk("bus_last", BUS_LAST, m_xfer && m_rem == 1);
    chk("cnt_rem", CNT_REM, m_xfer ? (m_rem % (1 << CW)) : 0);
    chk("bus_we", BUS_WE, m_busy && m_dir);
    if (m_busy) chk("bus_do", BUS_DO, RAM_Q[m_bank*DW +: DW]);
    chk("ram_d", RAM_D, BUS_DI);
    chk("ram_we", RAM_WE, (ack && !m_dir) ? oh : NBANK'(0));
    chk("ct_inc", CT_INC, (ack && !m_hold) ? oh : NBANK'(0));
    chk("cmd_ready", CMD_READY, e_ready);

    acc_we       += $countones(RAM_WE);
    acc_ct       += $countones(CT_INC);
    acc_last     += int'(BUS_LAST);
    acc_acked    += int'(CE && BUS_REQ && BUS_ACK);
    acc_busy_low += int'(!BUSY);
    acc_buswe    += int'(BUS_WE);

    if (CE) begin
      if (ABORT) begin
        model_reset();
      end else begin
        accept   = CMD_VALID && e_ready;
        done     = m_busy && BUS_END;
        was_idle = !m_busy;
        nc.dir = CMD_DIR; nc.bank = int'(CMD_BANK); nc.hold = CMD_HOLD; nc.cnt = int'(CMD_CNT);
        if (ack) begin
          m_rem--;
          if (m_rem == 0) m_xfer = 0;
        end
        if (done) begin
          m_busy = 0;
          m_xfer = 0;
        end
        if (QMODE) begin
          if ((was_idle || done) && mq.size() > 0) begin
            c = mq.pop_front();
            model_load(c);
          end
          if (accept) mq.push_back(nc);
        end else if (accept) begin
          model_load(nc);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ends;
    set_idle();
    model_reset();
    #12 RST_N = 1'b1;
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_req", BUS_REQ, 0);
    chk("rst_last", BUS_LAST, 0);
    chk("rst_we", BUS_WE, 0);
    chk("rst_cnt", CNT_REM, 0);
    chk("rst_ramwe", RAM_WE, 0);
    chk("rst_ctinc", CT_INC, 0);
    chk("rst_ready", CMD_READY, 1);

    // Bank 2, three words into RAM, ack every cycle (also while idle and waiting).
    set_idle(); clear_acc();
    s_valid = 1; s_bank = 2; s_cnt = 3; s_ack = 1;
    step();
    s_valid = 0;
    repeat (6) step();
    s_ack = 0; s_end = 1; step();
    s_end = 0; step();
    chk("d1_ramwe_pulses", acc_we, 3);
    chk("d1_ctinc_pulses", acc_ct, 3);
    chk("d1_last_cycles", acc_last, 1);
    chk("d1_busy_after_end", BUSY, 0);

    // Count 0 means 256 words.
    set_idle(); clear_acc();
    s_valid = 1; s_cnt = 0; s_bank = 1;
    step();
    s_valid = 0;
    for (int i = 0; i < 4 && !BUSY; i++) step();
    chk("d2_cnt_before_ack", CNT_REM, 0);
    chk("d2_last_before_ack", BUS_LAST, 0);
    s_ack = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!BUS_REQ) break;
    end
    chk("d2_words_acked", acc_acked, 256);
    s_ack = 0; s_end = 1; step();
    s_end = 0; step();

    // RAM to bus with held bank counter.
    set_idle(); clear_acc();
    s_valid = 1; s_dir = 1; s_hold = 1; s_bank = 3; s_cnt = 4; s_ack = 1;
    step();
    s_valid = 0;
    repeat (7) step();
    s_ack = 0; s_end = 1; step();
    s_end = 0; step();
    chk("d3_ramwe_pulses", acc_we, 0);
    chk("d3_ctinc_pulses", acc_ct, 0);
    chk("d3_words_acked", acc_acked, 4);
    chk("d3_bus_we_seen", acc_buswe > 0, 1);

`ifdef SCU_DSP_DMA_QUEUE_EN
    // Three commands pushed while busy; the fourth offer stalls, then they run back to back.
    set_idle(); clear_acc();
    s_valid = 1; s_cnt = 2; s_bank = 0; step();
    s_bank = 1; step();
    s_bank = 3; step();
    s_bank = 2; step();
    chk("d4_ready_when_full", CMD_READY, 0);
    s_valid = 0;
    clear_acc();
    ends = 0;
    for (int i = 0; i < 60 && ends < 3; i++) begin
      s_ack = 1;
      s_end = m_busy && !m_xfer;
      step();
      if (BUS_END && BUSY) ends++;
    end
    chk("d4_ends", ends, 3);
    chk("d4_busy_gaps", acc_busy_low, 0);
    chk("d4_words_acked", acc_acked, 6);
    set_idle(); step();
    chk("d4_idle_after", BUSY, 0);
`endif

    // Abort with five words left (and one queued when the queue exists).
    set_idle(); clear_acc();
    s_valid = 1; s_cnt = 7; s_bank = 3; step();
`ifdef SCU_DSP_DMA_QUEUE_EN
    s_cnt = 2; step();
`endif
    s_valid = 0;
    for (int i = 0; i < 12; i++) begin
      if (BUSY && CNT_REM == 8'd5) break;
      s_ack = m_busy && m_rem > 5;
      step();
    end
    chk("d5_cnt_at_abort", CNT_REM, 5);
    s_ack = 0; s_abort = 1; step();
    s_abort = 0; step();
    chk("d5_busy", BUSY, 0);
    chk("d5_req", BUS_REQ, 0);
    chk("d5_ready", CMD_READY, 1);
    repeat (3) step();
    chk("d5_queue_empty", BUSY, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s_ce    = ($urandom_range(9) != 0);
      s_valid = ($urandom_range(2) == 0);
      s_dir   = 1'($urandom_range(1));
      s_hold  = 1'($urandom_range(1));
      s_bank  = int'($urandom_range(NBANK - 1));
      s_cnt   = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(6, 1));
      s_ack   = ($urandom_range(9) < 6);
      s_end   = (m_busy && !m_xfer) ? ($urandom_range(3) == 0) : ($urandom_range(29) == 0);
      s_abort = ($urandom_range(99) == 0);
      step();
    end

    // Reset in the middle of a transfer with ACK held high.
    set_idle(); s_abort = 1; step();
    set_idle(); s_valid = 1; s_cnt = 5; s_bank = 1; step();
    s_valid = 0;
    for (int i = 0; i < 4 && !BUSY; i++) step();
    s_ack = 1; step();
    #1 RST_N = 1'b0;
    #1;
    chk("rst_mid_req", BUS_REQ, 0);
    chk("rst_mid_ramwe", RAM_WE, 0);
    chk("rst_mid_ctinc", CT_INC, 0);
    chk("rst_mid_busy", BUSY, 0);
    model_reset();
    #2 RST_N = 1'b1;
    set_idle(); s_ack = 1;
    repeat (3) step();
    chk("rst_mid_no_restart", BUSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
